keypad_matrix_emu: RTL

//  Behavioural-synthesisable 4x4 key-matrix responder: plays the keypad side of the row-scan interface.

---
 rtl/keypad_pkg.sv | 30 +++
 rtl/keypad_bounce_lfsr.sv | 26 ++
 rtl/keypad_matrix_emu.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad emulator and its scanner benches.
// Key code = 4*row + col; column lines are active-low.
package keypad_pkg;

    typedef enum logic [4:0] {
        IDLE       = 5'b00001,
        BOUNCE_IN  = 5'b00010,
        HOLD       = 5'b00100,
        BOUNCE_OUT = 5'b01000,
        GAP        = 5'b10000
    } key_state_t;

    localparam logic [3:0]  COL_IDLE   = 4'b1111;
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;

    function automatic logic [1:0] code_row(input logic [3:0] code);
        return code[3:2];
    endfunction

    function automatic logic [1:0] code_col(input logic [3:0] code);
        return code[1:0];
    endfunction

    // Right-shifting Galois form: feedback taps applied when bit 0 shifts out.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/keypad_bounce_lfsr.sv
// 16-bit Galois LFSR used to generate contact bounce noise.
// NEXT_BIT is bit 0 of the value the register takes on the next STEP.
module keypad_bounce_lfsr
    import keypad_pkg::*;
(
    input  logic CLK,
    input  logic RST,
    input  logic STEP,
    output logic NEXT_BIT
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    assign lfsr_d   = lfsr_next(lfsr_q);
    assign NEXT_BIT = lfsr_d[0];

    always_ff @(posedge CLK) begin
        if (RST) begin
            lfsr_q <= LFSR_SEED;
        end else if (STEP) begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/keypad_matrix_emu.sv
// 4x4 key-matrix responder: plays the keypad side of a row-scan interface.
// Define KEYPAD_EMU_BOUNCE_EN to add LFSR-driven make/break bounce windows.
module keypad_matrix_emu
    import keypad_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES   = 2_000_000,
    parameter int unsigned BOUNCE_CYCLES = 250_000,
    parameter int unsigned GAP_CYCLES    = 500_000,
    parameter int unsigned CNT_W         = 24
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       PRESS_VALID,
    input  logic [3:0] PRESS_CODE,
    output logic       PRESS_READY,
    input  logic [3:0] KEY_ROW,
    output logic [3:0] KEY_COL,
    output logic       BUSY,
    output logic       DONE
);

    localparam int unsigned      HOLD_N  = (HOLD_CYCLES == 0) ? 1 : HOLD_CYCLES;
    localparam int unsigned      GAP_N   = (GAP_CYCLES == 0) ? 1 : GAP_CYCLES;
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_N - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_N - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    key_state_t       state;
    logic [3:0]       code_q;
    logic [CNT_W-1:0] cnt;
    logic             contact;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;
    logic             accept;
    logic             cnt_zero;

    assign accept   = PRESS_VALID & ready_q;
    assign cnt_zero = (cnt == '0);

`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam int unsigned      BOUNCE_N  = (BOUNCE_CYCLES == 0) ? 1 : BOUNCE_CYCLES;
    localparam logic [CNT_W-1:0] BOUNCE_LD = CNT_W'(BOUNCE_N - 1);

    logic lfsr_step;
    logic bounce_bit;

    // Step on exactly the edges that load a fresh noise bit into contact,
    // so each bounce cycle sees the LFSR value it was sampled from.
    assign lfsr_step = ((state == IDLE)       &&  accept)   ||
                       ((state == BOUNCE_IN)  && !cnt_zero) ||
                       ((state == HOLD)       &&  cnt_zero) ||
                       ((state == BOUNCE_OUT) && !cnt_zero);

    keypad_bounce_lfsr u_lfsr (
        .CLK      (CLK),
        .RST      (RST),
        .STEP     (lfsr_step),
        .NEXT_BIT (bounce_bit)
    );
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            code_q  <= '0;
            cnt     <= '0;
            contact <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        code_q  <= PRESS_CODE;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
`ifdef KEYPAD_EMU_BOUNCE_EN
                        state   <= BOUNCE_IN;
                        cnt     <= BOUNCE_LD;
                        contact <= (BOUNCE_LD == '0) ? 1'b1 : bounce_bit;
`else
                        state   <= HOLD;
                        cnt     <= HOLD_LD;
                        contact <= 1'b1;
`endif
                    end
                end
`ifdef KEYPAD_EMU_BOUNCE_EN
                BOUNCE_IN: begin
                    if (cnt_zero) begin
                        state   <= HOLD;
                        cnt     <= HOLD_LD;
                        contact <= 1'b1;
                    end else begin
                        cnt     <= cnt - CNT_ONE;
                        contact <= (cnt == CNT_ONE) ? 1'b1 : bounce_bit;
                    end
                end
`endif
                HOLD: begin
                    if (cnt_zero) begin
`ifdef KEYPAD_EMU_BOUNCE_EN
                        state   <= BOUNCE_OUT;
                        cnt     <= BOUNCE_LD;
                        contact <= (BOUNCE_LD == '0) ? 1'b0 : bounce_bit;
`else
                        state   <= GAP;
                        cnt     <= GAP_LD;
                        contact <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
`ifdef KEYPAD_EMU_BOUNCE_EN
                BOUNCE_OUT: begin
                    if (cnt_zero) begin
                        state   <= GAP;
                        cnt     <= GAP_LD;
                        contact <= 1'b0;
                    end else begin
                        cnt     <= cnt - CNT_ONE;
                        contact <= (cnt == CNT_ONE) ? 1'b0 : bounce_bit;
                    end
                end
`endif
                GAP: begin
                    if (cnt_zero) begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    contact <= 1'b0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Zero-cycle path: only the pressed key's own row line is examined.
    always_comb begin
        KEY_COL = COL_IDLE;
        if (contact && !KEY_ROW[code_row(code_q)]) begin
            KEY_COL[code_col(code_q)] = 1'b0;
        end
    end

    assign PRESS_READY = ready_q;
    assign BUSY        = busy_q;
    assign DONE        = done_q;

endmodule
